// File: rtl/mm_pkg.sv
// Shared types and constants for the 32x32 matrix-multiply engine.
// Covers operand formats, FSM states and the operand memory map.
package mm_pkg;

   localparam int unsigned N         = 32;
   localparam int unsigned VLEN      = 16;
   localparam int unsigned RES_W     = 24;
   localparam int unsigned RAM_WORDS = 2176;
   localparam int unsigned ADDR_W    = 12;
   // 16 products of up to +64 reach +1024, which needs 12 signed bits
   localparam int unsigned P_W       = 12;

   localparam logic [ADDR_W-1:0] A_BASE  = 12'd0;
   localparam logic [ADDR_W-1:0] B_BASE  = 12'd1024;
   localparam logic [ADDR_W-1:0] SA_BASE = 12'd2048;
   localparam logic [ADDR_W-1:0] SB_BASE = 12'd2112;

   typedef enum logic [1:0] {
      MODE_INT8 = 2'd0,
      MODE_INT4 = 2'd1,
      MODE_VSQ  = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StComp = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic logic signed [7:0] decode_elem(input logic [7:0] raw, input mode_e mode);
      if (mode == MODE_INT8) return raw;
      return {{4{raw[3]}}, raw[3:0]};
   endfunction

endpackage

// File: rtl/mm_acc.sv
// Result register file: one write port, synchronous clear of every entry.
module mm_acc
   import mm_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             we,
   input  logic [9:0]       addr,
   input  logic [RES_W-1:0] data
);

   logic [RES_W-1:0] registers [0:N*N-1];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int unsigned n = 0; n < N * N; n++) registers[n] <= '0;
      end else if (we) begin
         registers[addr] <= data;
      end
   end

endmodule

// File: rtl/mm_ram.sv
// Operand memory: elements on two combinational ports, VSQ scale nibbles on two more.
// Contents are preloaded from outside and never reset.
module mm_ram
   import mm_pkg::*;
(
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [ADDR_W-1:0] addr_sa,
   input  logic [ADDR_W-1:0] addr_sb,
   output logic [7:0]        data_a,
   output logic [7:0]        data_b,
   output logic [3:0]        scale_a,
   output logic [3:0]        scale_b
);

   logic [7:0] mem [0:RAM_WORDS-1];

   assign data_a  = mem[addr_a];
   assign data_b  = mem[addr_b];
   assign scale_a = mem[addr_sa][3:0];
   assign scale_b = mem[addr_sb][3:0];

endmodule

// File: rtl/mm_ctrl.sv
// Matrix-multiply engine top: FSM, i/j/k sweep and one MAC per cycle.
// Results land in acc.registers; o_done flags completion of the whole product.
module mm_ctrl
   import mm_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_mode,
   input  logic       i_start,
   output logic       o_done
);

   state_e state_q, state_d;
   mode_e  mode_q, mode_d;
   logic [4:0] i_q, j_q, k_q;
   logic signed [RES_W-1:0] sum_q, sum_d, sum_next;
   logic signed [P_W-1:0]   p_q, p_d, p_next;
   logic [ADDR_W-1:0] addr_a, addr_b, addr_sa, addr_sb;
   logic [7:0] raw_a, raw_b, scale_prod;
   logic [3:0] scale_a, scale_b;
   logic signed [7:0]  elem_a, elem_b;
   logic signed [15:0] prod;
   logic signed [RES_W-1:0] prod_ext, p_ext, scale_ext, scaled;
   logic accept, last, vec_end, row_end, acc_we;

   assign accept  = i_start && (state_q != StComp);
   assign row_end = (k_q == 5'd31);
   assign vec_end = (k_q[3:0] == 4'hF);
   assign last    = row_end && (j_q == 5'd31) && (i_q == 5'd31);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (i_start) state_d = StComp;
         StComp:         if (last) state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   always_comb begin
      o_done = (state_q == StDone);
      acc_we = (state_q == StComp) && row_end;
   end

   always_comb begin
      unique case (i_mode)
         2'd1:    mode_d = MODE_INT4;
         2'd2:    mode_d = MODE_VSQ;
         default: mode_d = MODE_INT8;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q <= MODE_INT8;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         sum_q  <= '0;
         p_q    <= '0;
      end else if (accept) begin
         mode_q <= mode_d;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         sum_q  <= '0;
         p_q    <= '0;
      end else if (state_q == StComp) begin
         k_q   <= k_q + 5'd1;
         if (row_end) j_q <= j_q + 5'd1;
         if (row_end && (j_q == 5'd31)) i_q <= i_q + 5'd1;
         sum_q <= sum_d;
         p_q   <= p_d;
      end
   end

   always_comb begin
      addr_a  = A_BASE + {2'd0, i_q, k_q};
      addr_b  = B_BASE + {2'd0, k_q, j_q};
      addr_sa = SA_BASE + {6'd0, i_q, k_q[4]};
      addr_sb = SB_BASE + {6'd0, j_q, k_q[4]};
   end

   always_comb begin
      elem_a     = decode_elem(raw_a, mode_q);
      elem_b     = decode_elem(raw_b, mode_q);
      prod       = elem_a * elem_b;
      prod_ext   = {{(RES_W-16){prod[15]}}, prod};
      p_next     = p_q + $signed(prod[P_W-1:0]);
      p_ext      = {{(RES_W-P_W){p_next[P_W-1]}}, p_next};
      scale_prod = {4'd0, scale_a} * {4'd0, scale_b};
      scale_ext  = {{(RES_W-8){1'b0}}, scale_prod};
      scaled     = p_ext * scale_ext;
      sum_next   = sum_q;
      p_d        = '0;
      if (mode_q == MODE_VSQ) begin
         // Each 16-element vector is scaled once, on its last element
         if (vec_end) sum_next = sum_q + scaled;
         else         p_d      = p_next;
      end else begin
         sum_next = sum_q + prod_ext;
      end
      sum_d = row_end ? '0 : sum_next;
   end

   mm_ram ram_a (
      .addr_a  (addr_a),
      .addr_b  (addr_b),
      .addr_sa (addr_sa),
      .addr_sb (addr_sb),
      .data_a  (raw_a),
      .data_b  (raw_b),
      .scale_a (scale_a),
      .scale_b (scale_b)
   );

   mm_acc acc (
      .clk   (i_clk),
      .clear (i_rst),
      .we    (acc_we),
      .addr  ({i_q, j_q}),
      .data  (sum_next)
   );

endmodule

// File: tb/tb_mm_ctrl.sv
// Bench for mm_ctrl: uniform-fill vector table, random images against an arithmetic
// reference, one full timed run, restart-from-DONE and mid-run reset sequences.
module tb_mm_ctrl;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode  = 2'd0;
   logic       done;

   always #5 clk = ~clk;

   mm_ctrl dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_mode  (mode),
      .i_start (start),
      .o_done  (done)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] img [0:2175];

   typedef struct {
      int         mode;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sa0, sa1, sb0, sb1;
      int         exp;
   } vec_t;
   vec_t vecs [8];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int elem(input logic [7:0] b, input int m);
      if (m == 1 || m == 2) return b[3] ? int'(b[3:0]) - 16 : int'(b[3:0]);
      return b[7] ? int'(b) - 256 : int'(b);
   endfunction

   // Reference result for entry (i,j), straight from the dot-product definition
   function automatic int model(input int i, input int j, input int m);
      int sum = 0;
      int p;
      int md = (m == 3) ? 0 : m;
      for (int v = 0; v < 2; v++) begin
         p = 0;
         for (int kk = v * 16; kk < v * 16 + 16; kk++)
            p += elem(img[i*32+kk], md) * elem(img[1024+kk*32+j], md);
         if (md == 2) sum += p * int'(img[2048+2*i+v][3:0]) * int'(img[2112+2*j+v][3:0]);
         else         sum += p;
      end
      return sum;
   endfunction

   function automatic int rows_bad(input int nrows, input int m);
      int bad = 0;
      logic [23:0] e;
      for (int idx = 0; idx < nrows * 32; idx++) begin
         e = 24'(model(idx / 32, idx % 32, m));
         if (dut.acc.registers[idx] !== e) bad++;
      end
      return bad;
   endfunction

   function automatic int nonzero_regs(input int count);
      int bad = 0;
      for (int idx = 0; idx < count; idx++)
         if (dut.acc.registers[idx] !== 24'd0) bad++;
      return bad;
   endfunction

   task automatic load_img();
      for (int a = 0; a < 2176; a++) dut.ram_a.mem[a] = img[a];
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic start_run(input int m);
      mode  = 2'(m);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic fill_identity();
      for (int a = 0; a < 2176; a++) img[a] = 8'd0;
      for (int i = 0; i < 32; i++) img[i*32+i] = 8'd1;
      for (int k = 0; k < 32; k++)
         for (int j = 0; j < 32; j++) img[1024+k*32+j] = 8'(k * 32 + j);
      load_img();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int bad;
      vecs[0] = '{0, 8'h80, 8'h80, 4'd0, 4'd0, 4'd0, 4'd0, 524288};
      vecs[1] = '{1, 8'hF8, 8'hF8, 4'd0, 4'd0, 4'd0, 4'd0, 2048};
      vecs[2] = '{2, 8'h01, 8'h01, 4'd2, 4'd3, 4'd4, 4'd5, 368};
      vecs[3] = '{2, 8'h01, 8'h01, 4'd0, 4'd0, 4'd0, 4'd0, 0};
      vecs[4] = '{3, 8'h80, 8'h80, 4'd0, 4'd0, 4'd0, 4'd0, 524288};
      vecs[5] = '{1, 8'h7F, 8'h7F, 4'd0, 4'd0, 4'd0, 4'd0, 32};
      vecs[6] = '{0, 8'h7F, 8'h81, 4'd0, 4'd0, 4'd0, 4'd0, -516128};
      vecs[7] = '{2, 8'hF7, 8'h09, 4'hF, 4'hF, 4'hF, 4'hF, -352800};

      tick(1);
      reset_dut();
      check("reset done", 24'(done), 24'd0);
      check("reset regs", 24'(nonzero_regs(1024)), 24'd0);
      tick(5);
      check("idle done", 24'(done), 24'd0);

      // Uniform fills: row 0 completes after 1024 cycles, row 1 not yet
      foreach (vecs[t]) begin
         for (int a = 0; a < 1024; a++) img[a] = vecs[t].a;
         for (int a = 1024; a < 2048; a++) img[a] = vecs[t].b;
         for (int r = 0; r < 32; r++) begin
            img[2048+2*r] = {4'hF, vecs[t].sa0};
            img[2049+2*r] = {4'hF, vecs[t].sa1};
            img[2112+2*r] = {4'hF, vecs[t].sb0};
            img[2113+2*r] = {4'hF, vecs[t].sb1};
         end
         load_img();
         start_run(vecs[t].mode);
         tick(1024);
         check($sformatf("vec%0d reg0", t), dut.acc.registers[0], 24'(vecs[t].exp));
         check($sformatf("vec%0d reg31", t), dut.acc.registers[31], 24'(vecs[t].exp));
         check($sformatf("vec%0d reg32", t), dut.acc.registers[32], 24'd0);
         check($sformatf("vec%0d done", t), 24'(done), 24'd0);
         reset_dut();
      end

      for (int r = 0; r < 3; r++) begin
         int m;
         for (int a = 0; a < 2176; a++) img[a] = 8'($urandom);
         m = int'($urandom_range(0, 3));
         load_img();
         start_run(m);
         tick(2048);
         check($sformatf("random%0d mode%0d bad", r, m), 24'(rows_bad(2, m)), 24'd0);
         reset_dut();
      end

      // Full INT8 run; a start pulse mid-run must not disturb it.
      // Edges are counted with the start-sampling edge as number 1.
      fill_identity();
      start_run(0);
      n = 1;
      while (done !== 1'b1 && n < 40000) begin
         start = (n == 500);
         mode  = (n == 500) ? 2'd1 : 2'd0;
         tick(1);
         n++;
      end
      start = 1'b0;
      check("done latency", 24'(n), 24'd32769);
      check("int8 golden bad", 24'(rows_bad(32, 0)), 24'd0);
      check("int8 reg1", dut.acc.registers[1], 24'd1);
      check("int8 reg130", dut.acc.registers[130], 24'hFFFF82);
      tick(3);
      check("done holds", 24'(done), 24'd1);

      // Restart from DONE with a new mode
      start_run(1);
      check("restart drops done", 24'(done), 24'd0);
      tick(1024);
      check("int4 row0 bad", 24'(rows_bad(1, 1)), 24'd0);
      check("int4 reg9", dut.acc.registers[9], 24'hFFFFF9);
      check("old reg32 kept", dut.acc.registers[32], 24'd32);
      reset_dut();

      // Reset during cycle 1000 of a run
      start_run(0);
      tick(999);
      reset_dut();
      check("abort done", 24'(done), 24'd0);
      check("abort regs", 24'(nonzero_regs(1024)), 24'd0);
      bad = 0;
      for (int a = 0; a < 2176; a++) if (dut.ram_a.mem[a] !== img[a]) bad++;
      check("ram kept", 24'(bad), 24'd0);
      tick(1100);
      check("abort stays idle", 24'(nonzero_regs(64)), 24'd0);
      check("abort no done", 24'(done), 24'd0);
      start_run(0);
      tick(1024);
      check("rerun row0 bad", 24'(rows_bad(1, 0)), 24'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
